// File: rtl/start_screen_draw.sv
// Start-screen overlay stage: maps the VGA timing stream to image ROM addresses and
// blends the returned 4-bit grey pixel over the background, keeping timing aligned (2-cycle latency).
module start_screen_draw #(
  parameter int X0    = 80,
  parameter int Y0    = 150,
  parameter int IMG_W = 160,
  parameter int IMG_H = 75,
  parameter int SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [18:0] rom_addr,
  input  logic [3:0]  rom_data,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  // Free-running pipeline: no valid/ready handshake, one pixel enters and one leaves every clock.
  localparam logic [11:0] X_LO = 12'(X0);
  localparam logic [11:0] X_HI = 12'(X0 + (IMG_W << SHIFT));
  localparam logic [11:0] Y_LO = 12'(Y0);
  localparam logic [11:0] Y_HI = 12'(Y0 + (IMG_H << SHIFT));

  logic [11:0] h_ext, v_ext, rel_x, rel_y;
  logic        in_win;
  logic [18:0] addr_calc;

  // Zero-extended 12-bit compares keep positions left/above the window from wrapping into it.
  assign h_ext  = {1'b0, hcount_in};
  assign v_ext  = {1'b0, vcount_in};
  assign rel_x  = h_ext - X_LO;
  assign rel_y  = v_ext - Y_LO;
  assign in_win = enable && (h_ext >= X_LO) && (h_ext < X_HI) &&
                  (v_ext >= Y_LO) && (v_ext < Y_HI);

  assign addr_calc = 19'(rel_y >> SHIFT) * 19'(IMG_W) + 19'(rel_x >> SHIFT);

  logic        in_win_q;
  logic [11:0] rgb_q;
  logic [10:0] hcount_d1, vcount_d1;
  logic        hsync_d1, vsync_d1, hblnk_d1, vblnk_d1;
  logic [11:0] rgb_next;

  // Blank dominates; ROM index 0 is transparent.
  always_comb begin
    rgb_next = rgb_q;
    if (hblnk_d1 || vblnk_d1) begin
      rgb_next = 12'h000;
    end else if (in_win_q && (rom_data != 4'h0)) begin
      rgb_next = {rom_data, rom_data, rom_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr   <= '0;
      in_win_q   <= 1'b0;
      rgb_q      <= '0;
      hcount_d1  <= '0;
      vcount_d1  <= '0;
      hsync_d1   <= 1'b0;
      vsync_d1   <= 1'b0;
      hblnk_d1   <= 1'b0;
      vblnk_d1   <= 1'b0;
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      rom_addr   <= in_win ? addr_calc : '0;
      in_win_q   <= in_win;
      rgb_q      <= rgb_in;
      hcount_d1  <= hcount_in;
      vcount_d1  <= vcount_in;
      hsync_d1   <= hsync_in;
      vsync_d1   <= vsync_in;
      hblnk_d1   <= hblnk_in;
      vblnk_d1   <= vblnk_in;
      hcount_out <= hcount_d1;
      vcount_out <= vcount_d1;
      hsync_out  <= hsync_d1;
      vsync_out  <= vsync_d1;
      hblnk_out  <= hblnk_d1;
      vblnk_out  <= vblnk_d1;
      rgb_out    <= rgb_next;
    end
  end

endmodule
